iter_ctrl: RTL and testbench

- Moore FSM that sequences the shared 3-bit iteration counter and the shift/add datapath of the iterative multiplier unit.
- Accepts a start/ready request from the host and loads the operands.
- Clears the counter, then runs one add-then-shift iteration per count until the counter reports terminal count 5.
- Returns a result-valid flag that is held until the host acknowledges it.

---
 rtl/iter_ctrl_pkg.sv | 20 ++
 rtl/iter_ctrl.sv | 95 +++++++++
 tb/tb_iter_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/iter_ctrl_pkg.sv
// Shared types and constants for the iterative-multiplier sequencer.
// The counter that produces counter_is_done lives beside iter_ctrl at unit level.
package iter_ctrl_pkg;

    // Width of the shared iteration counter and the count at which it flags done.
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned ITER_TC = 5;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        INIT   = 3'd2,
        SETTLE = 3'd3,
        CHECK  = 3'd4,
        ADD    = 3'd5,
        SHIFT  = 3'd6,
        DONE   = 3'd7
    } state_e;

endpackage

// File: rtl/iter_ctrl.sv
// Sequencer for the shift/add multiplier: load, clear, then ITER_TC add/shift
// iterations gated by the external counter's terminal-count flag.
module iter_ctrl
    import iter_ctrl_pkg::*;
#(
    parameter bit SKIP_ZERO_ADD = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic abort,
    input  logic ack,
    input  logic q0,
    input  logic counter_is_done,
    output logic ready,
    output logic busy,
    output logic ld_a,
    output logic ld_b,
    output logic InitZcnt,
    output logic cnt,
    output logic init_acc,
    output logic add_en,
    output logic shift,
    output logic done
);

    state_e state_q, state_d;

    // NOTE: state holds only through non-blocking assignments so every reader sees the pre-edge value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every output and state_d gets a default before the case, so no path infers a latch.
        state_d  = state_q;
        ready    = 1'b0;
        ld_a     = 1'b0;
        ld_b     = 1'b0;
        InitZcnt = 1'b0;
        cnt      = 1'b0;
        init_acc = 1'b0;
        add_en   = 1'b0;
        shift    = 1'b0;
        done     = 1'b0;

        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (start) state_d = LOAD;
            end
            LOAD: begin
                ld_a    = 1'b1;
                ld_b    = 1'b1;
                state_d = INIT;
            end
            INIT: begin
                InitZcnt = 1'b1;
                init_acc = 1'b1;
                state_d  = SETTLE;
            end
            // One idle cycle so the registered terminal-count flag catches up with the count.
            SETTLE: state_d = CHECK;
            CHECK: begin
                if (counter_is_done)             state_d = DONE;
                else if (!SKIP_ZERO_ADD || q0)   state_d = ADD;
                else                             state_d = SHIFT;
            end
            ADD: begin
                // q0 comes from the multiplier register and cannot change while in ADD.
                add_en  = SKIP_ZERO_ADD ? 1'b1 : q0;
                state_d = SHIFT;
            end
            SHIFT: begin
                shift   = 1'b1;
                cnt     = 1'b1;
                state_d = SETTLE;
            end
            DONE: begin
                done = 1'b1;
                if (ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (abort) state_d = IDLE;
    end

    assign busy = (state_q != IDLE) && (state_q != DONE);

endmodule

// File: tb/tb_iter_ctrl.sv
// Directed bench for iter_ctrl: two instances (SKIP_ZERO_ADD=1 and 0), each paired
// with a behavioural counter and multiplier shift register.
module tb_iter_ctrl;
    import iter_ctrl_pkg::*;

    localparam logic [9:0] IDLE_OUT = 10'b10_0000_0000;
    localparam logic [9:0] DONE_OUT = 10'b00_0000_0001;
    localparam int B_BUSY = 8, B_LDA = 7, B_LDB = 6, B_INIT = 5, B_CNT = 4;
    localparam int B_IACC = 3, B_ADD = 2, B_SHIFT = 1, B_DONE = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, abort, ack, start_s, start_a;
    logic [4:0] mult_s, mult_a;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- instance with SKIP_ZERO_ADD = 1 ----------------
    logic q0_s, cid_s, ready_s, busy_s, ld_a_s, ld_b_s, initz_s, cnt_s, iacc_s, add_s, shift_s, done_s;
    logic [CNT_W-1:0] count_s;
    logic [4:0] mreg_s;
    logic [9:0] out_s;

    iter_ctrl #(.SKIP_ZERO_ADD(1'b1)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .abort(abort), .ack(ack),
        .q0(q0_s), .counter_is_done(cid_s),
        .ready(ready_s), .busy(busy_s), .ld_a(ld_a_s), .ld_b(ld_b_s),
        .InitZcnt(initz_s), .cnt(cnt_s), .init_acc(iacc_s), .add_en(add_s),
        .shift(shift_s), .done(done_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_s <= '0;
            cid_s   <= 1'b0;
            mreg_s  <= '0;
        end else begin
            if (initz_s)    count_s <= '0;
            else if (cnt_s) count_s <= count_s + 1'b1;
            cid_s <= (count_s == CNT_W'(ITER_TC));
            if (ld_b_s)       mreg_s <= mult_s;
            else if (shift_s) mreg_s <= mreg_s >> 1;
        end
    end
    assign q0_s  = mreg_s[0];
    assign out_s = {ready_s, busy_s, ld_a_s, ld_b_s, initz_s, cnt_s, iacc_s, add_s, shift_s, done_s};

    // ---------------- instance with SKIP_ZERO_ADD = 0 ----------------
    logic q0_a, cid_a, ready_a, busy_a, ld_a_a, ld_b_a, initz_a, cnt_a, iacc_a, add_a, shift_a, done_a;
    logic [CNT_W-1:0] count_a;
    logic [4:0] mreg_a;
    logic [9:0] out_a;

    iter_ctrl #(.SKIP_ZERO_ADD(1'b0)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort), .ack(ack),
        .q0(q0_a), .counter_is_done(cid_a),
        .ready(ready_a), .busy(busy_a), .ld_a(ld_a_a), .ld_b(ld_b_a),
        .InitZcnt(initz_a), .cnt(cnt_a), .init_acc(iacc_a), .add_en(add_a),
        .shift(shift_a), .done(done_a)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_a <= '0;
            cid_a   <= 1'b0;
            mreg_a  <= '0;
        end else begin
            if (initz_a)    count_a <= '0;
            else if (cnt_a) count_a <= count_a + 1'b1;
            cid_a <= (count_a == CNT_W'(ITER_TC));
            if (ld_b_a)       mreg_a <= mult_a;
            else if (shift_a) mreg_a <= mreg_a >> 1;
        end
    end
    assign q0_a  = mreg_a[0];
    assign out_a = {ready_a, busy_a, ld_a_a, ld_b_a, initz_a, cnt_a, iacc_a, add_a, shift_a, done_a};

    // ---------------- checking and stimulus helpers ----------------
    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Starts an operation (start high before edge E0) and watches until done or abort.
    task automatic run_op(input int sel, input logic [4:0] mult, input int abort_at,
                          output int ld_e, output int init_e, output int n_ld, output int n_cnt,
                          output int n_add, output int n_shift, output int n_idle, output int done_e);
        logic [9:0] o;
        int e;
        e = -1; ld_e = -1; init_e = -1; done_e = -1;
        n_ld = 0; n_cnt = 0; n_add = 0; n_shift = 0; n_idle = 0;
        if (sel != 0) begin mult_a = mult; start_a = 1'b1; end
        else          begin mult_s = mult; start_s = 1'b1; end
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            e++;
            #1;
            if (e == 0) begin start_s = 1'b0; start_a = 1'b0; end
            o = (sel != 0) ? out_a : out_s;
            if (o[B_LDA] && o[B_LDB]) begin n_ld++; if (ld_e < 0) ld_e = e; end
            if (o[B_INIT] && o[B_IACC] && init_e < 0) init_e = e;
            if (o[B_CNT])   n_cnt++;
            if (o[B_ADD])   n_add++;
            if (o[B_SHIFT]) n_shift++;
            if (!o[B_BUSY] && !o[B_DONE]) n_idle++;
            if (abort_at > 0 && o[B_SHIFT] && n_shift == abort_at) begin
                abort = 1'b1;
                break;
            end
            if (o[B_DONE]) begin
                done_e = e;
                break;
            end
        end
    endtask

    task automatic finish_done(input int sel, input string tag);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check({tag, "_done_hold"}, int'((sel != 0) ? out_a : out_s), int'(DONE_OUT));
        end
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
        check({tag, "_after_ack"}, int'((sel != 0) ? out_a : out_s), int'(IDLE_OUT));
    endtask

    int ld_e, init_e, n_ld, n_cnt, n_add, n_shift, n_idle, done_e;

    initial begin
        rst = 1'b1; abort = 1'b0; ack = 1'b0;
        start_s = 1'b0; start_a = 1'b0; mult_s = '0; mult_a = '0;

        // Reset state and idle hold
        #12;
        check("rst_out_s", int'(out_s), int'(IDLE_OUT));
        check("rst_out_a", int'(out_a), int'(IDLE_OUT));
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check("idle_s", int'(out_s), int'(IDLE_OUT));
        end

        // Full-add run, q0=1 throughout
        run_op(0, 5'b11111, 0, ld_e, init_e, n_ld, n_cnt, n_add, n_shift, n_idle, done_e);
        check("full_ld_edge", ld_e, 0);
        check("full_init_edge", init_e, 1);
        check("full_ld_pulses", n_ld, 1);
        check("full_cnt", n_cnt, 5);
        check("full_add", n_add, 5);
        check("full_shift", n_shift, 5);
        check("full_not_busy", n_idle, 0);
        check("full_done_edge", done_e, 24);

        // Back-to-back: start held high with ack in DONE, stale flag at INIT
        start_s = 1'b1; ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
        check("b2b_ack_to_idle", int'(out_s), int'(IDLE_OUT));
        run_op(0, 5'b11111, 0, ld_e, init_e, n_ld, n_cnt, n_add, n_shift, n_idle, done_e);
        check("b2b_ld_edge", ld_e, 0);
        check("b2b_cnt", n_cnt, 5);
        check("b2b_shift", n_shift, 5);
        check("b2b_done_edge", done_e, 24);
        finish_done(0, "b2b");

        // Zero-add run, q0=0 throughout
        run_op(0, 5'b00000, 0, ld_e, init_e, n_ld, n_cnt, n_add, n_shift, n_idle, done_e);
        check("zero_add", n_add, 0);
        check("zero_cnt", n_cnt, 5);
        check("zero_done_edge", done_e, 19);
        finish_done(0, "zero");

        // Mixed pattern with skipping: 3 adds, 2 skipped
        run_op(0, 5'b10101, 0, ld_e, init_e, n_ld, n_cnt, n_add, n_shift, n_idle, done_e);
        check("mix_skip_add", n_add, 3);
        check("mix_skip_cnt", n_cnt, 5);
        check("mix_skip_done_edge", done_e, 22);
        finish_done(0, "mix_skip");

        // Abort right after the 3rd SHIFT, then a fresh full operation
        run_op(0, 5'b11111, 3, ld_e, init_e, n_ld, n_cnt, n_add, n_shift, n_idle, done_e);
        check("abort_reached_shift3", n_shift, 3);
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_to_idle", int'(out_s), int'(IDLE_OUT));
        run_op(0, 5'b11111, 0, ld_e, init_e, n_ld, n_cnt, n_add, n_shift, n_idle, done_e);
        check("post_abort_cnt", n_cnt, 5);
        check("post_abort_add", n_add, 5);
        check("post_abort_done_edge", done_e, 24);

        // Abort out of DONE without ack
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_from_done", int'(out_s), int'(IDLE_OUT));

        // ack outside DONE is ignored
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
        check("ack_in_idle", int'(out_s), int'(IDLE_OUT));

        // SKIP_ZERO_ADD=0, q0 alternating 1,0,1,0,1: ADD every iteration
        run_op(1, 5'b10101, 0, ld_e, init_e, n_ld, n_cnt, n_add, n_shift, n_idle, done_e);
        check("all_add", n_add, 3);
        check("all_cnt", n_cnt, 5);
        check("all_shift", n_shift, 5);
        check("all_done_edge", done_e, 24);
        finish_done(1, "all");

        // Asynchronous reset mid-run
        mult_a = 5'b11111;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        for (int k = 0; k < 8; k++) @(posedge clk);
        #1;
        check("pre_rst_busy", int'(busy_a), 1);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_out", int'(out_a), int'(IDLE_OUT));
        #2;
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_idle", int'(out_a), int'(IDLE_OUT));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
